// File: rtl/rcpa_error_monitor.sv
// Error monitor for the N-bit approximate ripple-carry adder: computes ED = |exact - approx|
// per sample and reports count/sum/max over windows of WIN samples via a valid/ready port.
module rcpa_error_monitor #(
    parameter  int N     = 8,
    parameter  int WIN   = 256,
    localparam int CNT_W = $clog2(WIN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           A,
    input  logic [N-1:0]           B,
    input  logic [N-1:0]           sum,
    input  logic                   fn,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       err_count,
    output logic [N+CNT_W:0]       ed_sum,
    output logic [N:0]             ed_max
);
    localparam int SUM_W = N + 1 + CNT_W;

    typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_nz_q, s1_nz_d;
    logic [N:0]         s1_ed_q, s1_ed_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [N:0]         max_q, max_d;

    logic [N:0]         exact, approx, ed_in;
    logic               accept, last;

    always_comb begin
        exact  = {1'b0, A} + {1'b0, B};
        approx = {fn, sum};
        ed_in  = (exact >= approx) ? (exact - approx) : (approx - exact);
        accept = in_valid && in_ready_q;
        last   = (cnt_q == CNT_W'(WIN - 1));

        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        sum_d       = sum_q;
        max_d       = max_q;

        s1_valid_d = accept;
        s1_ed_d    = ed_in;
        s1_nz_d    = (ed_in != '0);

        if (s1_valid_q) begin
            err_d = err_q + CNT_W'(s1_nz_q);
            sum_d = sum_q + SUM_W'(s1_ed_q);
            if (s1_ed_q > max_q) max_d = s1_ed_q;
        end

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (last) begin
                        cnt_d      = '0;
                        in_ready_d = 1'b0;
                        state_d    = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The last sample folds while s1_valid is high; report on the edge after.
                if (!s1_valid_q) begin
                    state_d     = REPORT;
                    out_valid_d = 1'b1;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    err_d       = '0;
                    sum_d       = '0;
                    max_d       = '0;
                end
            end
            default: begin
                state_d     = ACCUM;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_nz_q     <= 1'b0;
            s1_ed_q     <= '0;
            err_q       <= '0;
            sum_q       <= '0;
            max_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_nz_q     <= s1_nz_d;
            s1_ed_q     <= s1_ed_d;
            err_q       <= err_d;
            sum_q       <= sum_d;
            max_q       <= max_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign err_count = err_q;
    assign ed_sum    = sum_q;
    assign ed_max    = max_q;
endmodule

// File: tb/tb_rcpa_error_monitor.sv
// Randomized bench for rcpa_error_monitor: a WIN=4 and a WIN=1 instance checked against
// a window-level reference model built from plain integer arithmetic.
module tb_rcpa_error_monitor;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIN=4 instance
    logic          iv, ir, f, ov, ordy;
    logic [N-1:0]  a, b, s;
    logic [2:0]    ec;
    logic [11:0]   es;
    logic [8:0]    em;

    // WIN=1 instance
    logic          iv1, ir1, f1, ov1, ordy1;
    logic [N-1:0]  a1, b1, s1;
    logic [0:0]    ec1;
    logic [9:0]    es1;
    logic [8:0]    em1;

    rcpa_error_monitor #(.N(N), .WIN(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .A(a), .B(b), .sum(s), .fn(f),
        .out_valid(ov), .out_ready(ordy), .err_count(ec), .ed_sum(es), .ed_max(em));

    rcpa_error_monitor #(.N(N), .WIN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1), .sum(s1), .fn(f1),
        .out_valid(ov1), .out_ready(ordy1), .err_count(ec1), .ed_sum(es1), .ed_max(em1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int ed_of(input int xa, input int xb, input int xs, input int xf);
        int ex, ap;
        ex = xa + xb;
        ap = xf * (1 << N) + xs;
        return (ex > ap) ? ex - ap : ap - ex;
    endfunction

    // Window-level model of the WIN=4 instance
    int  m_eds[$];
    bit  m_busy, m_ov, m_zero, rand_ordy;
    int  m_lat, m_err, m_sum, m_max;

    task automatic model_reset();
        m_eds.delete();
        m_busy = 0; m_ov = 0; m_lat = 0;
        m_err = 0; m_sum = 0; m_max = 0;
    endtask

    // One clock of the WIN=4 instance: entered and left at a falling edge.
    task automatic cyc();
        bit acc;
        chk("in_ready", ir, !m_busy);
        chk("out_valid", ov, m_ov);
        if (m_ov || m_zero) begin
            chk("err_count", ec, m_err);
            chk("ed_sum", es, m_sum);
            chk("ed_max", em, m_max);
        end
        m_zero = 0;
        if (rand_ordy) ordy = 1'($urandom % 2);
        acc = iv && !m_busy && !rst;
        @(posedge clk);
        if (rst) begin
            model_reset();
            m_zero = 1;
        end else begin
            if (m_ov && ordy) begin
                m_ov = 0; m_busy = 0; m_zero = 1;
                m_err = 0; m_sum = 0; m_max = 0;
            end
            if (m_lat > 0) begin
                m_lat--;
                if (m_lat == 0) m_ov = 1;
            end
            if (acc) begin
                m_eds.push_back(ed_of(a, b, s, f));
                if (m_eds.size() == 4) begin
                    m_err = 0; m_sum = 0; m_max = 0;
                    foreach (m_eds[i]) begin
                        if (m_eds[i] != 0) m_err++;
                        m_sum += m_eds[i];
                        if (m_eds[i] > m_max) m_max = m_eds[i];
                    end
                    m_eds.delete();
                    m_busy = 1;
                    m_lat  = 2;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input int xa, input int xb, input int xs, input int xf);
        a = N'(xa); b = N'(xb); s = N'(xs); f = 1'(xf); iv = 1'b1;
        for (int k = 0; k < 200; k++) begin
            bit took;
            took = !m_busy && !rst;
            cyc();
            if (took) begin
                iv = 1'b0;
                return;
            end
        end
        iv = 1'b0;
        chk("send_timeout", 1, 0);
    endtask

    task automatic flush();
        iv = 1'b0; ordy = 1'b1;
        for (int k = 0; k < 20 && m_busy; k++) cyc();
        chk("flush_timeout", m_busy, 0);
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic rand_sample();
        int xa, xb, t;
        xa = int'($urandom % 256);
        xb = int'($urandom % 256);
        t  = xa + xb;
        if ($urandom % 2 == 0) send(xa, xb, t % 256, t / 256);
        else send(xa, xb, int'($urandom % 256), int'($urandom % 4 == 0));
    endtask

    initial begin
        rst = 1'b1;
        iv = 0; a = 0; b = 0; s = 0; f = 0; ordy = 1;
        iv1 = 0; a1 = 0; b1 = 0; s1 = 0; f1 = 0; ordy1 = 1;
        rand_ordy = 0; m_zero = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // exact samples: zero error report
        repeat (4) send(10, 20, 30, 0);
        flush();
        // single large error: exact 256 vs approx 0
        send(255, 1, 0, 0);
        repeat (3) send(10, 20, 30, 0);
        flush();
        // ED 2,5,0,5 including approx > exact
        send(3, 4, 9, 0); send(10, 10, 15, 0); send(10, 20, 30, 0); send(0, 0, 5, 0);
        flush();

        // backpressure: report held with in_valid high throughout
        ordy = 1'b0;
        repeat (4) send(7, 9, 1, 1);
        a = 8'd1; b = 8'd2; s = 8'd50; f = 1'b0; iv = 1'b1;
        repeat (12) cyc();
        iv = 1'b0;
        ordy = 1'b1;
        flush();

        // reset mid-window discards partial statistics
        send(0, 0, 7, 0); send(0, 0, 7, 0);
        do_reset();
        repeat (4) rand_sample();
        flush();
        // reset mid-report
        ordy = 1'b0;
        repeat (4) send(100, 100, 0, 0);
        repeat (3) cyc();
        do_reset();
        ordy = 1'b1;

        // random windows, random gaps and random out_ready
        rand_ordy = 1;
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom % 3) begin
                    a = 8'($urandom); s = 8'($urandom); iv = 1'b0;
                    cyc();
                end
                rand_sample();
            end
        end
        rand_ordy = 0;
        flush();

        // WIN=1: continuous input, every sample reported 2 edges after its accept
        begin
            int q_ed[$], q_cy[$];
            int cyno, nrep;
            bit took;
            cyno = 0; nrep = 0;
            for (int k = 0; k < 60; k++) begin
                if (ov1) begin
                    if (q_ed.size() == 0) chk("w1_spurious", 1, 0);
                    else begin
                        int e, c;
                        e = q_ed.pop_front();
                        c = q_cy.pop_front();
                        nrep++;
                        chk("w1_err_count", ec1, (e != 0) ? 1 : 0);
                        chk("w1_ed_sum", es1, e);
                        chk("w1_ed_max", em1, e);
                        chk("w1_latency", cyno - c, 2);
                    end
                end
                a1 = 8'($urandom); b1 = 8'($urandom);
                s1 = ($urandom % 2 == 0) ? 8'(a1 + b1) : 8'($urandom);
                f1 = 1'($urandom % 2);
                iv1 = (k < 50);
                took = iv1 && ir1;
                @(posedge clk);
                cyno++;
                if (took) begin
                    q_ed.push_back(ed_of(int'(a1), int'(b1), int'(s1), int'(f1)));
                    q_cy.push_back(cyno);
                end
                @(negedge clk);
            end
            chk("w1_drained", q_ed.size(), 0);
            chk("w1_enough_reports", nrep >= 10, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
